// File: rtl/conv33_pkg.sv
// Shared constants and state encoding for the conv33 weight feeder.
package conv33_pkg;

   localparam int KERNEL_TAPS = 9;
   localparam int TAP_W       = 4;
   localparam int ACK_CNT_W   = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      READ,
      DRAIN,
      WAIT_ACK,
      HOLD
   } state_t;

endpackage

// File: rtl/conv33_rd_pipe.sv
// Two-stage valid/data delay from weight memory to the loader beat outputs.
module conv33_rd_pipe #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic                  stage1_valid,
   output logic                  load_en,
   output logic [DATA_WIDTH-1:0] load_data
);

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1_valid <= 1'b0;
         load_en      <= 1'b0;
         load_data    <= '0;
      end else begin
         stage1_valid <= rd_en;
         load_en      <= stage1_valid;
         if (stage1_valid)
            load_data <= rdata;
      end
   end

endmodule

// File: rtl/conv33_weight_feeder.sv
// Streams 3x3 kernels from weight memory into the conv33 weight loader,
// one kernel per clear/load/ack/hold handshake.
module conv33_weight_feeder
   import conv33_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int NUM_KERNELS = 16,
   parameter int BASE_ADDR   = 0,
   parameter int ACK_TIMEOUT = 15,
   localparam int IDX_W      = $clog2(NUM_KERNELS) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  next_kernel,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  loader_clr,
   output logic                  load_en,
   output logic [DATA_WIDTH-1:0] load_data,
   input  logic                  weight_load,
   output logic [IDX_W-1:0]      kernel_idx,
   output logic                  kernel_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [TAP_W-1:0]      tap_cnt;
   logic [ACK_CNT_W-1:0]  ack_cnt;
   logic                  stage1_valid;

   assign busy = (state != IDLE);

   conv33_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rd_pipe (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (mem_rd_en),
      .rdata       (mem_rdata),
      .stage1_valid(stage1_valid),
      .load_en     (load_en),
      .load_data   (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         addr_cnt     <= ADDR_WIDTH'(BASE_ADDR);
         tap_cnt      <= '0;
         ack_cnt      <= '0;
         mem_rd_en    <= 1'b0;
         mem_addr     <= '0;
         loader_clr   <= 1'b0;
         kernel_idx   <= '0;
         kernel_ready <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         loader_clr <= 1'b0;
         done       <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state      <= CLEAR;
                  loader_clr <= 1'b1;
                  kernel_idx <= '0;
                  addr_cnt   <= ADDR_WIDTH'(BASE_ADDR);
                  error      <= 1'b0;
               end
            end
            CLEAR: begin
               state     <= READ;
               mem_rd_en <= 1'b1;
               mem_addr  <= addr_cnt;
               addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
               tap_cnt   <= TAP_W'(1);
            end
            READ: begin
               if (tap_cnt == TAP_W'(KERNEL_TAPS)) begin
                  mem_rd_en <= 1'b0;
                  state     <= DRAIN;
               end else begin
                  mem_addr <= addr_cnt;
                  addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                  tap_cnt  <= tap_cnt + TAP_W'(1);
               end
            end
            DRAIN: begin
               // last beat is on load_en with nothing behind it
               if (load_en && !stage1_valid) begin
                  state   <= WAIT_ACK;
                  ack_cnt <= '0;
               end
            end
            WAIT_ACK: begin
               if (weight_load) begin
                  state        <= HOLD;
                  kernel_ready <= 1'b1;
               end else if (ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                  state <= IDLE;
                  error <= 1'b1;
                  done  <= 1'b1;
               end else begin
                  ack_cnt <= ack_cnt + ACK_CNT_W'(1);
               end
            end
            HOLD: begin
               if (next_kernel) begin
                  kernel_ready <= 1'b0;
                  if (kernel_idx == IDX_W'(NUM_KERNELS - 1)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     state      <= CLEAR;
                     loader_clr <= 1'b1;
                     kernel_idx <= kernel_idx + IDX_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv33_weight_feeder.sv
// Scoreboard bench for conv33_weight_feeder: two-kernel run, timeout,
// mid-stream reset, ignored strobes, and a single-kernel offset run.
module tb_conv33_weight_feeder;

   localparam int DW = 8;
   localparam int AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, next_kernel;
   logic          mem_rd_en, loader_clr, load_en, weight_load;
   logic          kernel_ready, busy, done, error;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata, load_data;
   logic [1:0]    kernel_idx;

   logic          start1, next1, rd1, clr1, len1, wl1, rdy1, busy1, done1, err1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] rdata1, ldata1;
   logic [0:0]    kidx1;

   conv33_weight_feeder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_KERNELS(2),
      .BASE_ADDR(0), .ACK_TIMEOUT(15)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .next_kernel(next_kernel),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .loader_clr(loader_clr), .load_en(load_en), .load_data(load_data),
      .weight_load(weight_load), .kernel_idx(kernel_idx),
      .kernel_ready(kernel_ready), .busy(busy), .done(done), .error(error)
   );

   conv33_weight_feeder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_KERNELS(1),
      .BASE_ADDR(20), .ACK_TIMEOUT(15)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start1), .next_kernel(next1),
      .mem_rd_en(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
      .loader_clr(clr1), .load_en(len1), .load_data(ldata1),
      .weight_load(wl1), .kernel_idx(kidx1),
      .kernel_ready(rdy1), .busy(busy1), .done(done1), .error(err1)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // memory: word[a] = a + 1, one-cycle read latency
   always @(posedge clk) begin
      mem_rdata <= mem_rd_en ? DW'(mem_addr + 8'd1) : 8'd0;
      rdata1    <= rd1 ? DW'(addr1 + 8'd1) : 8'd0;
   end

   // loader model: stores beats, acks the cycle after its 9th beat
   logic [7:0] lw [9];
   int         lcnt = 0;
   logic       lacked = 1'b0;
   bit         ack_on;
   int         l1cnt = 0;

   always @(posedge clk) begin
      weight_load <= 1'b0;
      if (loader_clr) begin
         lcnt   <= 0;
         lacked <= 1'b0;
      end else begin
         if (load_en) begin
            if (lcnt < 9) lw[lcnt] <= load_data;
            lcnt <= lcnt + 1;
         end
         if (ack_on && !lacked && (lcnt == 9 || (load_en && lcnt == 8))) begin
            weight_load <= 1'b1;
            lacked      <= 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      wl1 <= 1'b0;
      if (clr1) l1cnt <= 0;
      else if (len1) begin
         l1cnt <= l1cnt + 1;
         if (l1cnt == 8) wl1 <= 1'b1;
      end
   end

   // scoreboard
   logic [7:0] aq[$], dq[$], aq1[$], dq1[$];

   always @(negedge clk) begin
      if (mem_rd_en) begin
         if (aq.size() == 0) chk("addr_extra", 1, 0);
         else chk("addr", mem_addr, aq.pop_front());
      end
      if (load_en) begin
         if (dq.size() == 0) chk("beat_extra", 1, 0);
         else chk("beat", load_data, dq.pop_front());
      end
      if (rd1) begin
         if (aq1.size() == 0) chk("addr1_extra", 1, 0);
         else chk("addr1", addr1, aq1.pop_front());
      end
      if (len1) begin
         if (dq1.size() == 0) chk("beat1_extra", 1, 0);
         else chk("beat1", ldata1, dq1.pop_front());
      end
   end

   task automatic push_k(input int base, input int k, input bit second);
      for (int i = 0; i < 9; i++) begin
         int a;
         a = base + 9 * k + i;
         if (second) begin
            aq1.push_back(8'(a));
            dq1.push_back(8'(a + 1));
         end else begin
            aq.push_back(8'(a));
            dq.push_back(8'(a + 1));
         end
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic pulse_next();
      next_kernel = 1'b1;
      @(posedge clk);
      #1 next_kernel = 1'b0;
   endtask

   task automatic wait_ready(input bit second);
      int n;
      n = 0;
      while (!(second ? rdy1 : kernel_ready) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(second ? "ready1_timeout" : "ready_timeout",
          second ? rdy1 : kernel_ready, 1);
   endtask

   task automatic chk_loader(input int first);
      for (int i = 0; i < 9; i++)
         chk($sformatf("loader_w%0d", i), lw[i], first + i);
      chk("loader_cnt", lcnt, 9);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; next_kernel = 1'b0;
      start1 = 1'b0; next1 = 1'b0; ack_on = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ctl", {busy, done, error, kernel_ready,
                      load_en, mem_rd_en, loader_clr}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_idx", kernel_idx, 0);
      rst = 1'b0;
      @(negedge clk);

      // kernel 0: exact timeline
      push_k(0, 0, 0);
      pulse_start();
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         chk($sformatf("clr_c%0d", n), loader_clr, n == 1);
         chk($sformatf("rd_c%0d", n), mem_rd_en, n >= 2 && n <= 10);
         chk($sformatf("ld_c%0d", n), load_en, n >= 4 && n <= 12);
         chk($sformatf("rdy_c%0d", n), kernel_ready, n == 14);
         chk($sformatf("busy_c%0d", n), busy, 1);
      end
      chk("kidx0", kernel_idx, 0);
      chk_loader(1);
      @(negedge clk);
      chk("rdy_hold", kernel_ready, 1);

      // kernel 1: stray start in READ, stray next_kernel in WAIT_ACK
      ack_on = 1'b0;
      push_k(0, 1, 0);
      pulse_next();
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("k1_clr", loader_clr, 1);
            chk("k1_idx", kernel_idx, 1);
            chk("k1_rdy_fall", kernel_ready, 0);
         end
         if (n == 4) pulse_start();
         if (n == 14) begin
            chk("k1_wait_busy", busy, 1);
            pulse_next();
         end
      end
      chk("nk_ign_rdy", kernel_ready, 0);
      chk("nk_ign_idx", kernel_idx, 1);
      chk("nk_ign_busy", busy, 1);
      ack_on = 1'b1;
      wait_ready(0);
      chk_loader(10);
      chk("q_empty_a", aq.size() + dq.size(), 0);
      pulse_next();
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_rdy", kernel_ready, 0);
      @(negedge clk);
      chk("done_fall", done, 0);
      chk("idle_stays", busy, 0);

      // ack timeout
      ack_on = 1'b0;
      push_k(0, 0, 0);
      pulse_start();
      for (int n = 1; n <= 28; n++) begin
         @(negedge clk);
         if (n == 27) begin
            chk("to_err_early", error, 0);
            chk("to_busy_early", busy, 1);
         end
         if (n == 28) begin
            chk("to_err", error, 1);
            chk("to_done", done, 1);
            chk("to_idle", busy, 0);
         end
      end
      @(negedge clk);
      chk("to_done_fall", done, 0);
      chk("to_err_sticky", error, 1);

      // restart clears error, then reset mid-stream
      ack_on = 1'b1;
      push_k(0, 0, 0);
      pulse_start();
      for (int n = 1; n <= 7; n++) begin
         @(negedge clk);
         if (n == 1) chk("err_clr", error, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_ctl", {busy, done, error, kernel_ready,
                       load_en, mem_rd_en, loader_clr}, 0);
      chk("mrst_addr", mem_addr, 0);
      chk("mrst_data", load_data, 0);
      aq.delete();
      dq.delete();
      rst = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         chk("post_rst_ld", load_en, 0);
      end
      push_k(0, 0, 0);
      pulse_start();
      wait_ready(0);
      chk_loader(1);
      chk("q_empty_d", aq.size() + dq.size(), 0);

      // single-kernel run at base 20
      push_k(20, 0, 1);
      start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      wait_ready(1);
      chk("k1run_idx", kidx1, 0);
      chk("q_empty_f", aq1.size() + dq1.size(), 0);
      next1 = 1'b1;
      @(posedge clk);
      #1 next1 = 1'b0;
      @(negedge clk);
      chk("k1run_done", done1, 1);
      chk("k1run_busy", busy1, 0);
      chk("k1run_rdy", rdy1, 0);
      chk("k1run_err", err1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
